// File: rtl/lsu_split_access.sv
// Multi-cycle load/store unit: byte-lane placement, load extension and hardware
// splitting of word-boundary-crossing accesses into two aligned bus beats.
module lsu_split_access #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [2:0]          req_func3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   output logic                resp_valid,
   output logic                resp_err,
   output logic [XLEN-1:0]     resp_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_mask,
   input  logic                mem_rsp_valid,
   input  logic [XLEN-1:0]     mem_rdata
);
   localparam int BYTES = XLEN / 8;
   localparam int OFFW  = $clog2(BYTES);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ0 = 3'd1;
   localparam logic [2:0] S_RSP0 = 3'd2;
   localparam logic [2:0] S_REQ1 = 3'd3;
   localparam logic [2:0] S_RSP1 = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   function automatic logic legal_f3(input logic we, input logic [2:0] f3);
      logic ok;
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
         3'b011, 3'b110:                         ok = (XLEN == 64);
         default:                                ok = 1'b0;
      endcase
      return ok && !(we && f3[2]);
   endfunction

   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] f3);
      logic [XLEN-1:0] keep;
      logic            sgn;
      case (f3[1:0])
         2'b00:   begin keep = XLEN'(8'hFF);          sgn = raw[7];  end
         2'b01:   begin keep = XLEN'(16'hFFFF);       sgn = raw[15]; end
         2'b10:   begin keep = XLEN'(32'hFFFF_FFFF);  sgn = raw[31]; end
         default: begin keep = {XLEN{1'b1}};          sgn = 1'b0;    end
      endcase
      if (sgn && !f3[2]) begin
         return (raw & keep) | ~keep;
      end else begin
         return raw & keep;
      end
   endfunction

   logic [2:0]          state_r;
   logic                req_ready_r, resp_valid_r, resp_err_r, mem_req_valid_r, mem_we_r;
   logic [XLEN-1:0]     resp_rdata_r, mem_wdata_r, buf_lo_r, buf_hi_r, wdata_hi_r;
   logic [ADDR_W-1:0]   mem_addr_r, addr_hi_r;
   logic [BYTES-1:0]    mem_mask_r, mask_hi_r;
   logic                we_r, split_r;
   logic [2:0]          func3_r;
   logic [OFFW-1:0]     off_r;

   logic [2:0]          nxt_s;
   logic                accept_s, legal_s, split_s, rsp0_s, rsp1_s, done_err_s;
   logic [3:0]          sz_s;
   logic [OFFW-1:0]     off_s;
   logic [2*BYTES-1:0]  szmask_s, lmask_s;
   logic [XLEN-1:0]     dmask_s, done_rdata_s, lo_eff_s, hi_eff_s;
   logic [2*XLEN-1:0]   ldata_s;
   logic [OFFW+1:0]     end_s;

   // Lane placement of the incoming request: mask/data pair spanning two words
   always_comb begin
      off_s    = req_addr[OFFW-1:0];
      sz_s     = 4'd1 << req_func3[1:0];
      szmask_s = ((2*BYTES)'(1) << sz_s) - (2*BYTES)'(1);
      lmask_s  = szmask_s << off_s;
      dmask_s  = {XLEN{1'b0}};
      for (int i = 0; i < BYTES; i++) begin
         dmask_s[8*i +: 8] = {8{szmask_s[i]}};
      end
      if (req_we) begin
         ldata_s = {{XLEN{1'b0}}, req_wdata & dmask_s} << {off_s, 3'b000};
      end else begin
         ldata_s = {(2*XLEN){1'b0}};
      end
      end_s    = (OFFW+2)'(off_s) + (OFFW+2)'(sz_s);
      split_s  = end_s > (OFFW+2)'(BYTES);
      legal_s  = legal_f3(req_we, req_func3);
   end

   // Next state, and the response value latched when entering DONE
   always_comb begin
      accept_s = (state_r == S_IDLE) && req_valid;
      rsp0_s   = (state_r == S_RSP0) && mem_rsp_valid;
      rsp1_s   = (state_r == S_RSP1) && mem_rsp_valid;
      nxt_s    = state_r;
      case (state_r)
         S_IDLE: if (req_valid) nxt_s = legal_s ? S_REQ0 : S_DONE; else nxt_s = S_IDLE;
         S_REQ0: if (mem_req_ready) nxt_s = S_RSP0; else nxt_s = S_REQ0;
         S_RSP0: if (mem_rsp_valid) nxt_s = split_r ? S_REQ1 : S_DONE; else nxt_s = S_RSP0;
         S_REQ1: if (mem_req_ready) nxt_s = S_RSP1; else nxt_s = S_REQ1;
         S_RSP1: if (mem_rsp_valid) nxt_s = S_DONE; else nxt_s = S_RSP1;
         S_DONE: nxt_s = S_IDLE;
         default: nxt_s = S_IDLE;
      endcase
      // The beat arriving this cycle is merged directly so DONE carries final data
      lo_eff_s = (state_r == S_RSP0) ? mem_rdata : buf_lo_r;
      hi_eff_s = (state_r == S_RSP1) ? mem_rdata : buf_hi_r;
      done_err_s = (state_r == S_IDLE);
      if (done_err_s || we_r) begin
         done_rdata_s = {XLEN{1'b0}};
      end else begin
         done_rdata_s = extend(XLEN'({hi_eff_s, lo_eff_s} >> {off_r, 3'b000}), func3_r);
      end
   end

   // State, captured request and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= S_IDLE;
         req_ready_r     <= 1'b1;
         resp_valid_r    <= 1'b0;
         resp_err_r      <= 1'b0;
         resp_rdata_r    <= {XLEN{1'b0}};
         mem_req_valid_r <= 1'b0;
         mem_we_r        <= 1'b0;
         mem_addr_r      <= {ADDR_W{1'b0}};
         mem_wdata_r     <= {XLEN{1'b0}};
         mem_mask_r      <= {BYTES{1'b0}};
         buf_lo_r        <= {XLEN{1'b0}};
         buf_hi_r        <= {XLEN{1'b0}};
         wdata_hi_r      <= {XLEN{1'b0}};
         addr_hi_r       <= {ADDR_W{1'b0}};
         mask_hi_r       <= {BYTES{1'b0}};
         we_r            <= 1'b0;
         split_r         <= 1'b0;
         func3_r         <= 3'b000;
         off_r           <= {OFFW{1'b0}};
      end else begin
         state_r         <= nxt_s;
         req_ready_r     <= (nxt_s == S_IDLE);
         resp_valid_r    <= (nxt_s == S_DONE);
         mem_req_valid_r <= (nxt_s == S_REQ0) || (nxt_s == S_REQ1);
         if (accept_s && legal_s) begin
            we_r        <= req_we;
            func3_r     <= req_func3;
            off_r       <= off_s;
            split_r     <= split_s;
            addr_hi_r   <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}} + ADDR_W'(BYTES);
            wdata_hi_r  <= ldata_s[2*XLEN-1:XLEN];
            mask_hi_r   <= lmask_s[2*BYTES-1:BYTES];
            mem_we_r    <= req_we;
            mem_addr_r  <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
            mem_wdata_r <= ldata_s[XLEN-1:0];
            mem_mask_r  <= lmask_s[BYTES-1:0];
         end else if (rsp0_s && split_r) begin
            mem_addr_r  <= addr_hi_r;
            mem_wdata_r <= wdata_hi_r;
            mem_mask_r  <= mask_hi_r;
         end
         if (rsp0_s) buf_lo_r <= mem_rdata;
         if (rsp1_s) buf_hi_r <= mem_rdata;
         if ((nxt_s == S_DONE) && (state_r != S_DONE)) begin
            resp_err_r   <= done_err_s;
            resp_rdata_r <= done_rdata_s;
         end
      end
   end

   assign req_ready     = req_ready_r;
   assign resp_valid    = resp_valid_r;
   assign resp_err      = resp_err_r;
   assign resp_rdata    = resp_rdata_r;
   assign mem_req_valid = mem_req_valid_r;
   assign mem_we        = mem_we_r;
   assign mem_addr      = mem_addr_r;
   assign mem_wdata     = mem_wdata_r;
   assign mem_mask      = mem_mask_r;
endmodule

// File: tb/tb_lsu_split_access.sv
// Directed bench for lsu_split_access: a 32-bit and a 64-bit instance driven by
// a small behavioural memory that can stall each beat.
module tb_lsu_split_access;
   logic clk = 1'b0;
   logic rst;
   logic req_we;
   logic [2:0] req_func3;
   logic [31:0] req_addr;
   logic [63:0] req_wdata, mem_rdata;
   logic req_valid32, req_valid64, mem_req_ready32, mem_req_ready64, mem_rsp_valid32, mem_rsp_valid64;
   logic req_ready32, resp_valid32, resp_err32, mem_req_valid32, mem_we32;
   logic [31:0] resp_rdata32, mem_addr32, mem_wdata32;
   logic [3:0] mem_mask32;
   logic req_ready64, resp_valid64, resp_err64, mem_req_valid64, mem_we64;
   logic [63:0] resp_rdata64, mem_wdata64;
   logic [31:0] mem_addr64;
   logic [7:0] mem_mask64;

   int checks = 0;
   int errors = 0;

   int r_lat, r_nb;
   logic [31:0] r_addr[4];
   logic [7:0] r_mask[4];
   logic [63:0] r_wdata[4];
   logic r_we[4];
   logic [63:0] r_rdata;
   logic r_err, r_stable, r_rdy, r_post, r_anyvalid;

   always #5 clk = ~clk;

   lsu_split_access #(.XLEN(32), .ADDR_W(32)) dut32 (
      .clk(clk), .rst(rst), .req_valid(req_valid32), .req_ready(req_ready32), .req_we(req_we),
      .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
      .resp_valid(resp_valid32), .resp_err(resp_err32), .resp_rdata(resp_rdata32),
      .mem_req_valid(mem_req_valid32), .mem_req_ready(mem_req_ready32), .mem_we(mem_we32),
      .mem_addr(mem_addr32), .mem_wdata(mem_wdata32), .mem_mask(mem_mask32),
      .mem_rsp_valid(mem_rsp_valid32), .mem_rdata(mem_rdata[31:0]));

   lsu_split_access #(.XLEN(64), .ADDR_W(32)) dut64 (
      .clk(clk), .rst(rst), .req_valid(req_valid64), .req_ready(req_ready64), .req_we(req_we),
      .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid64), .resp_err(resp_err64), .resp_rdata(resp_rdata64),
      .mem_req_valid(mem_req_valid64), .mem_req_ready(mem_req_ready64), .mem_we(mem_we64),
      .mem_addr(mem_addr64), .mem_wdata(mem_wdata64), .mem_mask(mem_mask64),
      .mem_rsp_valid(mem_rsp_valid64), .mem_rdata(mem_rdata));

   function automatic logic [31:0] mw32(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'h4433_2211;
         32'h0000_0104: return 32'h8877_6655;
         32'hFFFF_FFFC: return 32'hCAFE_BABE;
         32'h0000_0000: return 32'h1357_9BDF;
         default:       return 32'h5A5A_5A5A;
      endcase
   endfunction

   function automatic logic [63:0] mw64(input logic [31:0] a);
      case (a)
         32'h0000_0008: return 64'h8877_6655_4433_2211;
         32'h0000_0010: return 64'h0011_2233_CAFE_F00D;
         default:       return 64'h5A5A_5A5A_5A5A_5A5A;
      endcase
   endfunction

   // One complete access; the bench acts as memory, stalling each beat by 'stall' cycles
   task automatic run(input bit sel, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [63:0] wd, input int stall);
      int cyc, hold;
      bit pend, got;
      logic [31:0] pend_addr, oa;
      logic [7:0] om;
      logic [63:0] ow;
      logic ov, owe;
      req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
      if (sel) req_valid64 = 1'b1; else req_valid32 = 1'b1;
      r_nb = 0; r_lat = -1; r_stable = 1'b1; r_rdy = 1'b1; r_anyvalid = 1'b0;
      r_err = 1'b0; r_rdata = 64'h0; got = 1'b0; pend = 1'b0; hold = 0; pend_addr = 32'h0;
      @(posedge clk); #1;
      req_valid32 = 1'b0; req_valid64 = 1'b0;
      cyc = 1;
      while (!got && cyc < 60) begin
         mem_req_ready32 = 1'b0; mem_req_ready64 = 1'b0;
         mem_rsp_valid32 = 1'b0; mem_rsp_valid64 = 1'b0;
         if (pend) begin
            if (sel) mem_rsp_valid64 = 1'b1; else mem_rsp_valid32 = 1'b1;
            mem_rdata = sel ? mw64(pend_addr) : {32'h0, mw32(pend_addr)};
            pend = 1'b0;
         end
         ov  = sel ? mem_req_valid64 : mem_req_valid32;
         oa  = sel ? mem_addr64 : mem_addr32;
         om  = sel ? mem_mask64 : {4'h0, mem_mask32};
         ow  = sel ? mem_wdata64 : {32'h0, mem_wdata32};
         owe = sel ? mem_we64 : mem_we32;
         if (ov && r_nb < 4) begin
            r_anyvalid = 1'b1;
            if (hold == 0) begin
               r_addr[r_nb] = oa; r_mask[r_nb] = om; r_wdata[r_nb] = ow; r_we[r_nb] = owe;
            end else if (oa !== r_addr[r_nb] || om !== r_mask[r_nb] || ow !== r_wdata[r_nb]) begin
               r_stable = 1'b0;
            end
            if (hold < stall) begin
               hold++;
            end else begin
               if (sel) mem_req_ready64 = 1'b1; else mem_req_ready32 = 1'b1;
               pend = 1'b1; pend_addr = oa; r_nb++; hold = 0;
            end
         end
         if (sel ? req_ready64 : req_ready32) r_rdy = 1'b0;
         if (sel ? resp_valid64 : resp_valid32) begin
            got = 1'b1; r_lat = cyc;
            r_err = sel ? resp_err64 : resp_err32;
            r_rdata = sel ? resp_rdata64 : {32'h0, resp_rdata32};
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      mem_req_ready32 = 1'b0; mem_req_ready64 = 1'b0;
      mem_rsp_valid32 = 1'b0; mem_rsp_valid64 = 1'b0;
      @(posedge clk); #1;
      r_post = sel ? (req_ready64 && !resp_valid64) : (req_ready32 && !resp_valid32);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({req_ready32, mem_req_valid32, resp_valid32, resp_err32} !== 4'b1000) begin errors++; $display("FAIL reset_ctl32 got %b want 1000", {req_ready32, mem_req_valid32, resp_valid32, resp_err32}); end
      checks++; if ({resp_rdata32, mem_addr32, mem_wdata32, mem_mask32, mem_we32} !== 101'h0) begin errors++; $display("FAIL reset_data32 got nonzero output"); end
      checks++; if ({req_ready64, mem_req_valid64, resp_valid64, resp_err64} !== 4'b1000) begin errors++; $display("FAIL reset_ctl64 got %b want 1000", {req_ready64, mem_req_valid64, resp_valid64, resp_err64}); end
      checks++; if ({resp_rdata64, mem_addr64, mem_wdata64, mem_mask64, mem_we64} !== 169'h0) begin errors++; $display("FAIL reset_data64 got nonzero output"); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_store_aligned;
      run(1'b0, 1'b1, 3'b010, 32'h0000_0100, 64'hDEAD_BEEF, 0);
      checks++; if (r_nb !== 1) begin errors++; $display("FAIL sw_beats got %0d want 1", r_nb); end
      checks++; if ({r_addr[0], r_mask[0], r_wdata[0][31:0], r_we[0]} !== {32'h100, 8'h0F, 32'hDEAD_BEEF, 1'b1}) begin errors++; $display("FAIL sw_beat0 got %h %h %h %b", r_addr[0], r_mask[0], r_wdata[0], r_we[0]); end
      checks++; if ({r_lat, r_err, r_rdata} !== {32'd3, 1'b0, 64'h0}) begin errors++; $display("FAIL sw_resp got lat %0d err %b rdata %h want 3 0 0", r_lat, r_err, r_rdata); end
      checks++; if ({r_rdy, r_post} !== 2'b11) begin errors++; $display("FAIL sw_ready got %b want 11", {r_rdy, r_post}); end
   endtask

   task automatic test_store_split;
      run(1'b0, 1'b1, 3'b001, 32'h0000_0103, 64'h0000_ABCD, 0);
      checks++; if (r_nb !== 2) begin errors++; $display("FAIL sh_beats got %0d want 2", r_nb); end
      checks++; if ({r_addr[0], r_mask[0], r_wdata[0][31:0]} !== {32'h100, 8'h08, 32'hCD00_0000}) begin errors++; $display("FAIL sh_beat0 got %h %h %h", r_addr[0], r_mask[0], r_wdata[0]); end
      checks++; if ({r_addr[1], r_mask[1], r_wdata[1][31:0]} !== {32'h104, 8'h01, 32'h0000_00AB}) begin errors++; $display("FAIL sh_beat1 got %h %h %h", r_addr[1], r_mask[1], r_wdata[1]); end
      checks++; if (r_lat !== 5) begin errors++; $display("FAIL sh_lat got %0d want 5", r_lat); end
   endtask

   task automatic test_loads32;
      run(1'b0, 1'b0, 3'b010, 32'h0000_0102, 64'h0, 0);
      checks++; if ({r_rdata, r_lat, r_nb} !== {64'h6655_4433, 32'd5, 32'd2}) begin errors++; $display("FAIL lw_split got %h lat %0d beats %0d want 66554433 5 2", r_rdata, r_lat, r_nb); end
      checks++; if ({r_mask[0], r_mask[1], r_wdata[0], r_we[0]} !== {8'h0C, 8'h03, 64'h0, 1'b0}) begin errors++; $display("FAIL lw_masks got %h %h %h %b", r_mask[0], r_mask[1], r_wdata[0], r_we[0]); end
      run(1'b0, 1'b0, 3'b000, 32'h0000_0107, 64'h0, 0);
      checks++; if ({r_rdata, r_lat, r_addr[0], r_mask[0]} !== {64'hFFFF_FF88, 32'd3, 32'h104, 8'h08}) begin errors++; $display("FAIL lb got %h lat %0d addr %h mask %h", r_rdata, r_lat, r_addr[0], r_mask[0]); end
      run(1'b0, 1'b0, 3'b100, 32'h0000_0107, 64'h0, 0);
      checks++; if (r_rdata !== 64'h0000_0088) begin errors++; $display("FAIL lbu got %h want 00000088", r_rdata); end
      run(1'b0, 1'b0, 3'b101, 32'h0000_0101, 64'h0, 0);
      checks++; if ({r_rdata, r_nb, r_mask[0]} !== {64'h0000_3322, 32'd1, 8'h06}) begin errors++; $display("FAIL lhu got %h beats %0d mask %h", r_rdata, r_nb, r_mask[0]); end
   endtask

   task automatic test_illegal;
      run(1'b0, 1'b0, 3'b011, 32'h0000_0100, 64'h0, 0);
      checks++; if ({r_anyvalid, r_err, r_lat, r_rdata} !== {1'b0, 1'b1, 32'd1, 64'h0}) begin errors++; $display("FAIL ld_on32 got valid %b err %b lat %0d rdata %h", r_anyvalid, r_err, r_lat, r_rdata); end
      run(1'b0, 1'b1, 3'b100, 32'h0000_0100, 64'h1234, 0);
      checks++; if ({r_anyvalid, r_err, r_lat, r_rdata} !== {1'b0, 1'b1, 32'd1, 64'h0}) begin errors++; $display("FAIL st_f3_100 got valid %b err %b lat %0d rdata %h", r_anyvalid, r_err, r_lat, r_rdata); end
      checks++; if (resp_err32 !== 1'b1) begin errors++; $display("FAIL err_hold got %b want 1", resp_err32); end
   endtask

   task automatic test_stall_wrap;
      run(1'b0, 1'b0, 3'b010, 32'hFFFF_FFFE, 64'h0, 3);
      checks++; if ({r_addr[0], r_mask[0], r_addr[1], r_mask[1]} !== {32'hFFFF_FFFC, 8'h0C, 32'h0, 8'h03}) begin errors++; $display("FAIL wrap_beats got %h %h %h %h", r_addr[0], r_mask[0], r_addr[1], r_mask[1]); end
      checks++; if ({r_stable, r_rdy, r_nb} !== {1'b1, 1'b1, 32'd2}) begin errors++; $display("FAIL wrap_hold got stable %b rdy %b beats %0d", r_stable, r_rdy, r_nb); end
      checks++; if ({r_rdata, r_err} !== {64'h9BDF_CAFE, 1'b0}) begin errors++; $display("FAIL wrap_data got %h err %b want 9bdfcafe 0", r_rdata, r_err); end
   endtask

   task automatic test_reset_midway;
      logic seen;
      req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h0000_0102; req_valid32 = 1'b1;
      @(posedge clk); #1; req_valid32 = 1'b0;
      mem_req_ready32 = 1'b1;
      @(posedge clk); #1; mem_req_ready32 = 1'b0;
      mem_rsp_valid32 = 1'b1; mem_rdata = 64'h4433_2211;
      @(posedge clk); #1; mem_rsp_valid32 = 1'b0;
      checks++; if ({mem_req_valid32, mem_addr32} !== {1'b1, 32'h104}) begin errors++; $display("FAIL mid_req1 got %b %h", mem_req_valid32, mem_addr32); end
      mem_req_ready32 = 1'b1;
      @(posedge clk); #1; mem_req_ready32 = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      checks++; if ({req_ready32, mem_req_valid32, resp_valid32} !== 3'b100) begin errors++; $display("FAIL mid_reset got %b want 100", {req_ready32, mem_req_valid32, resp_valid32}); end
      mem_rsp_valid32 = 1'b1; mem_rdata = 64'h8877_6655;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         mem_rsp_valid32 = 1'b0;
         seen = seen | resp_valid32 | mem_req_valid32 | !req_ready32;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_ignore got activity %b want 0", seen); end
      run(1'b0, 1'b0, 3'b100, 32'h0000_0107, 64'h0, 0);
      checks++; if ({r_rdata, r_lat} !== {64'h88, 32'd3}) begin errors++; $display("FAIL mid_after got %h lat %0d want 88 3", r_rdata, r_lat); end
   endtask

   task automatic test_xlen64;
      run(1'b1, 1'b0, 3'b011, 32'h0000_000C, 64'h0, 0);
      checks++; if ({r_addr[0], r_mask[0], r_addr[1], r_mask[1]} !== {32'h8, 8'hF0, 32'h10, 8'h0F}) begin errors++; $display("FAIL ld64_beats got %h %h %h %h", r_addr[0], r_mask[0], r_addr[1], r_mask[1]); end
      checks++; if ({r_rdata, r_lat} !== {64'hCAFE_F00D_8877_6655, 32'd5}) begin errors++; $display("FAIL ld64_data got %h lat %0d", r_rdata, r_lat); end
      run(1'b1, 1'b0, 3'b010, 32'h0000_000C, 64'h0, 0);
      checks++; if ({r_rdata, r_nb} !== {64'hFFFF_FFFF_8877_6655, 32'd1}) begin errors++; $display("FAIL lw64 got %h beats %0d", r_rdata, r_nb); end
      run(1'b1, 1'b0, 3'b110, 32'h0000_000C, 64'h0, 0);
      checks++; if (r_rdata !== 64'h0000_0000_8877_6655) begin errors++; $display("FAIL lwu64 got %h", r_rdata); end
      run(1'b1, 1'b1, 3'b011, 32'h0000_000C, 64'h1122_3344_5566_7788, 0);
      checks++; if ({r_wdata[0], r_wdata[1]} !== {64'h5566_7788_0000_0000, 64'h0000_0000_1122_3344}) begin errors++; $display("FAIL sd64_lanes got %h %h", r_wdata[0], r_wdata[1]); end
   endtask

   initial begin
      req_valid32 = 1'b0; req_valid64 = 1'b0; req_we = 1'b0; req_func3 = 3'b000;
      req_addr = 32'h0; req_wdata = 64'h0; mem_rdata = 64'h0;
      mem_req_ready32 = 1'b0; mem_req_ready64 = 1'b0; mem_rsp_valid32 = 1'b0; mem_rsp_valid64 = 1'b0;
      test_reset;
      test_store_aligned;
      test_store_split;
      test_loads32;
      test_illegal;
      test_stall_wrap;
      test_reset_midway;
      test_xlen64;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
